keypad_scan: RTL and testbench
==============================

Name: keypad_scan

Overview:
Input-side counterpart of the multiplexed 7-segment display driver: scans a 4x4 matrix keypad for the calculator by driving columns one at a time (active-low) and reading rows.
Debounces the detected press and emits a one-cycle strobe with a 4-bit key code.
Sits between the board keypad pins and the calculator control FSM.

Parameters:
SCAN_DIV, 40000, clk cycles per scan tick (column dwell time and sample period); minimum 2
DEBOUNCE_N, 4, consecutive identical tick samples required to accept a press or a release; minimum 2

Ports:
clk  input  1  system clock
rst  input  1  reset, synchronous, active-low
row_n  input  4  keypad rows, active-low, externally pulled up, asynchronous to clk
col_n  output  4  keypad column drive, active-low, exactly one bit low at all times
key_code  output  4  {row_idx[1:0], col_idx[1:0]} of the last accepted key
key_valid  output  1  one-clk strobe when a new press is accepted
key_held  output  1  high from acceptance until the release is accepted

Behaviour:
- Reset (rst==0 at a clk edge):
  - col_n=4'b1110, key_code=0, key_valid=0, key_held=0.
  - state=SCAN; prescaler, debounce counter, synchroniser and latched row/col are cleared (synchroniser to all-ones).
  - Applies mid-operation: any pending press is discarded and no strobe is issued.
- Synchroniser: row_n passes through 2 flops into rows_s.
- Prescaler: counts 0..SCAN_DIV-1 and wraps; tick=1 for the single cycle when count==SCAN_DIV-1. Runs in every state.
- A row sample counts as one valid key only when exactly one bit of rows_s is low. Zero or several low bits mean "no key".
- SCAN state:
  - On tick with no key: rotate col_n left (1110->1101->1011->0111->1110).
  - On tick with a valid key: latch row_idx and col_idx (index of the low col_n bit), set cnt=1, enter DEBOUNCE. col_n freezes.
- DEBOUNCE state:
  - On tick with the same single row low: cnt++.
  - When cnt reaches DEBOUNCE_N, the next clk has key_valid=1 for exactly one cycle, key_code is updated in that same cycle, key_held=1, and state=HELD.
  - On tick with a mismatch (other row, none, or several): cnt=0, state=SCAN, rotation resumes on the next tick.
- HELD state, col_n still frozen:
  - On tick with the latched row still low: cnt=0.
  - On tick with the row released (no low bits): cnt++. When cnt reaches DEBOUNCE_N, key_held=0 and state=SCAN.
  - A different row low counts as "not released": cnt=0.
  - No repeat strobes while held.
- Timing:
  - Minimum press-to-strobe latency: 2 (sync) + (DEBOUNCE_N-1)*SCAN_DIV + 1 clks after the detecting tick.
  - key_code holds its value between presses.
- cnt is sized to hold DEBOUNCE_N and must not overflow.
- Between ticks, state and outputs change only on the strobe cycle.

Decomposition:
- Shared package holds:
  - state encoding SCAN/DEBOUNCE/HELD (2-bit localparams);
  - COL_RESET=4'b1110;
  - the key-code field layout (row in bits [3:2], col in [1:0]).
- One sub-module, scan_tick: a generic parameterised prescaler (clk, rst, tick out) with the same synchronous active-low reset, reusable by the display driver.
- The FSM, synchroniser and column shifter stay in keypad_scan.

Test Plan:
All scenarios use SCAN_DIV=4 and DEBOUNCE_N=3.
1. Reset: hold rst=0 for 3 clks, then release. Expect col_n=1110, key_valid=0, key_held=0, key_code=0, and col_n stepping 1101, 1011, 0111, 1110 every 4 clks.
2. Clean press: drive row_n=1011 only while col_n=1101 (row2, col1), then hold it. Expect exactly one key_valid pulse with key_code=4'b1001, key_held=1, col_n frozen at 1101. Holding for 100 more clks produces no further pulses.
3. Bounce: assert the row for 2 ticks, then release. Expect no key_valid, key_held=0, scanning resumes.
4. Release: after scenario 2, set row_n=1111. Expect key_held to fall after the 3rd released tick and col_n rotation to resume. A glitch back low after 1 released tick restarts the release count.
5. Ghost/multi-key: row_n=1001 while any column is active. Expect no key_valid and uninterrupted rotation.
6. Reset mid-debounce: apply rst=0 one tick after detection. Expect no key_valid ever, outputs at reset values, col_n=1110.

Source files
------------

// File: rtl/keypad_scan_pkg.sv
// keypad_scan_pkg: state encoding, column reset pattern and key-code layout shared by the keypad scanner
package keypad_scan_pkg;
  localparam logic [1:0] ST_SCAN     = 2'd0;
  localparam logic [1:0] ST_DEBOUNCE = 2'd1;
  localparam logic [1:0] ST_HELD     = 2'd2;
  typedef enum logic [1:0] {
    SCAN     = ST_SCAN,
    DEBOUNCE = ST_DEBOUNCE,
    HELD     = ST_HELD
  } state_e;
  localparam logic [3:0] COL_RESET = 4'b1110;
  // Index of the single low bit in an active-low one-hot nibble
  function automatic logic [1:0] low_idx(input logic [3:0] v);
    return {~v[2] | ~v[3], ~v[1] | ~v[3]};
  endfunction
  // Key code layout: row in [3:2], column in [1:0]
  function automatic logic [3:0] make_code(input logic [1:0] row, input logic [1:0] col);
    return {row, col};
  endfunction
endpackage

// File: rtl/keypad_scan_tick.sv
// scan_tick: free-running prescaler emitting a one-cycle tick every DIV clocks
module scan_tick #(
  parameter int DIV = 40000
) (
  input  logic clk,
  input  logic rst,
  output logic tick_o
);
  localparam int W = (DIV > 1) ? $clog2(DIV) : 1;
  logic [W-1:0] cnt_q;
  assign tick_o = cnt_q == W'(DIV - 1);
  always_ff @(posedge clk) begin
    if (!rst) cnt_q <= '0;
    else      cnt_q <= tick_o ? '0 : cnt_q + 1'b1;
  end
endmodule

// File: rtl/keypad_scan.sv
// keypad_scan: 4x4 matrix keypad scanner with row synchroniser, debounce and one-cycle key strobe
module keypad_scan
  import keypad_scan_pkg::*;
#(
  parameter int SCAN_DIV   = 40000,
  parameter int DEBOUNCE_N = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] row_n,
  output logic [3:0] col_n,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held
);
  localparam int CW = $clog2(DEBOUNCE_N + 1);
  localparam logic [CW-1:0] DN = CW'(DEBOUNCE_N);
  state_e        state_q;
  logic [3:0]    col_q, code_q, rows_m_q, rows_s_q;
  logic [1:0]    row_q, colx_q, row_idx;
  logic [CW-1:0] cnt_q;
  logic          valid_q, held_q, tick, one_key, same, released;
  scan_tick #(.DIV(SCAN_DIV)) u_tick (.clk(clk), .rst(rst), .tick_o(tick));
  always_ff @(posedge clk) begin
    if (!rst) begin
      rows_m_q <= 4'hF;
      rows_s_q <= 4'hF;
    end else begin
      rows_m_q <= row_n;
      rows_s_q <= rows_m_q;
    end
  end
  assign one_key  = $countones(~rows_s_q) == 1;
  assign row_idx  = low_idx(rows_s_q);
  assign same     = one_key && row_idx == row_q;
  assign released = &rows_s_q;
  // Acceptance is acted on the clock after the count completes, so the strobe lands between ticks
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= SCAN;
      col_q   <= COL_RESET;
      code_q  <= '0;
      row_q   <= '0;
      colx_q  <= '0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      held_q  <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      case (state_q)
        SCAN: if (tick) begin
          if (one_key) begin
            row_q   <= row_idx;
            colx_q  <= low_idx(col_q);
            cnt_q   <= CW'(1);
            state_q <= DEBOUNCE;
          end else begin
            col_q <= {col_q[2:0], col_q[3]};
          end
        end
        DEBOUNCE: if (cnt_q == DN) begin
          valid_q <= 1'b1;
          code_q  <= make_code(row_q, colx_q);
          held_q  <= 1'b1;
          cnt_q   <= '0;
          state_q <= HELD;
        end else if (tick) begin
          cnt_q   <= same ? cnt_q + 1'b1 : '0;
          state_q <= same ? DEBOUNCE : SCAN;
        end
        HELD: if (tick) begin
          if (!released) begin
            cnt_q <= '0;
          end else if (cnt_q == DN - 1'b1) begin
            cnt_q   <= '0;
            held_q  <= 1'b0;
            state_q <= SCAN;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: state_q <= SCAN;
      endcase
    end
  end
  assign col_n     = col_q;
  assign key_code  = code_q;
  assign key_valid = valid_q;
  assign key_held  = held_q;
endmodule

// File: tb/tb_keypad_scan.sv
// tb_keypad_scan: physical keypad model plus tick-level reference; strobes checked from a scoreboard queue
module tb_keypad_scan;
  localparam int DIV = 4;
  localparam int N   = 3;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [3:0]  row_n, col_n, key_code;
  logic        key_valid, key_held;
  logic [15:0] keys = '0;
  logic [3:0]  force_low = '0;
  int          vec = 0;
  int          miss = 0;
  typedef struct {
    logic [3:0] code;
    longint     t;
  } exp_s;
  exp_s        q[$];
  exp_s        e;
  int          mmode, mcol, mcnt, lr, lc;
  logic [3:0]  mcode;

  keypad_scan #(.SCAN_DIV(DIV), .DEBOUNCE_N(N)) dut (
    .clk(clk), .rst(rst), .row_n(row_n), .col_n(col_n),
    .key_code(key_code), .key_valid(key_valid), .key_held(key_held)
  );

  always #5 clk = ~clk;

  // A pressed key (r,c) pulls row r low whenever column c is driven low
  function automatic logic [3:0] phys(input logic [3:0] cn, input logic [15:0] k, input logic [3:0] f);
    logic [3:0] v = ~f;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (k[r*4+c] && !cn[c]) v[r] = 1'b0;
    return v;
  endfunction

  function automatic logic [3:0] col_mask(input int c);
    logic [3:0] m = 4'b1111;
    m[c] = 1'b0;
    return m;
  endfunction

  always_comb row_n = phys(col_n, keys, force_low);

  task automatic chk(input string nm, input logic [3:0] act, input logic [3:0] exp);
    vec++;
    if (act !== exp) begin
      miss++;
      $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mmode = 0; mcol = 0; mcnt = 0; lr = 0; lc = 0; mcode = '0;
    q.delete();
  endtask

  // Reference behaviour evaluated once per tick on what the keypad presents to the active column
  task automatic model_tick();
    logic [3:0] s;
    int lows, r;
    s = phys(col_mask(mcol), keys, force_low);
    lows = 0; r = 0;
    for (int i = 0; i < 4; i++) if (!s[i]) begin lows++; r = i; end
    case (mmode)
      0: if (lows == 1) begin lr = r; lc = mcol; mcnt = 1; mmode = 1; end
         else mcol = (mcol + 1) % 4;
      1: if (lows == 1 && r == lr) begin
           mcnt++;
           if (mcnt == N) begin
             mcode = 4'(lr * 4 + lc);
             q.push_back('{mcode, longint'($time) + 15});
             mmode = 2; mcnt = 0;
           end
         end else begin mcnt = 0; mmode = 0; end
      default: if (s == 4'hF) begin
                 mcnt++;
                 if (mcnt == N) begin mmode = 0; mcnt = 0; end
               end else mcnt = 0;
    endcase
  endtask

  task automatic tick_cycle();
    repeat (DIV - 1) @(posedge clk);
    @(negedge clk);
    chk("col_n", col_n, col_mask(mcol));
    chk("key_held", {3'b0, key_held}, {3'b0, 1'(mmode == 2)});
    chk("key_code", key_code, mcode);
    @(posedge clk);
    model_tick();
    #1;
  endtask

  task automatic reset_dut();
    rst = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    model_reset();
    chk("rst_col_n", col_n, 4'b1110);
    chk("rst_valid", {3'b0, key_valid}, 4'b0);
    chk("rst_held", {3'b0, key_held}, 4'b0);
    chk("rst_code", key_code, 4'b0);
    rst = 1'b1;
  endtask

  always @(negedge clk) begin
    if (rst && key_valid) begin
      vec++;
      if (q.size() == 0) begin
        miss++;
        $display("FAIL strobe: unexpected key_valid with code %b at %0t", key_code, $time);
      end else begin
        e = q.pop_front();
        if (key_code !== e.code || longint'($time) != e.t) begin
          miss++;
          $display("FAIL strobe: got code %b at %0t expected %b at %0d", key_code, $time, e.code, e.t);
        end
      end
    end
  end

  initial begin
    int kind;
    model_reset();
    reset_dut();
    repeat (5) tick_cycle();
    keys = 16'b1 << (2*4 + 1);
    repeat (35) tick_cycle();
    keys = '0;
    tick_cycle();
    keys = 16'b1 << (2*4 + 1);
    tick_cycle();
    keys = '0;
    repeat (5) tick_cycle();
    force_low = 4'b0100;
    repeat (2) tick_cycle();
    force_low = '0;
    repeat (4) tick_cycle();
    force_low = 4'b0110;
    repeat (8) tick_cycle();
    force_low = '0;
    keys = 16'b1 << (1*4 + 3);
    for (int i = 0; i < 8 && mmode != 1; i++) tick_cycle();
    tick_cycle();
    reset_dut();
    keys = '0;
    repeat (6) tick_cycle();
    for (int s = 0; s < 40; s++) begin
      kind = int'($urandom_range(0, 3));
      keys = '0;
      force_low = '0;
      case (kind)
        1: keys[$urandom_range(0, 15)] = 1'b1;
        2: begin keys[$urandom_range(0, 15)] = 1'b1; keys[$urandom_range(0, 15)] = 1'b1; end
        3: force_low = 4'($urandom);
        default: ;
      endcase
      repeat ($urandom_range(1, 12)) tick_cycle();
    end
    keys = '0;
    force_low = '0;
    repeat (6) tick_cycle();
    @(negedge clk);
    vec++;
    if (q.size() != 0) begin
      miss++;
      $display("FAIL pending: %0d expected strobes never seen, required 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end
endmodule
